processing_core_ctrl: RTL and testbench

Multi-channel control FSM that dispatches commands to N_CH HLS processing cores over the ap_start/ap_ready/ap_done handshake and signals when each channel's result is available. It sits between the command decoder and the HLS core array. Each channel independently supports three modes:
- pass-through read;
- cumulative execute, released on ap_ready;
- cumulative execute, released on ap_done.

Each channel also has a hang-detection timeout and sticky error reporting.

---
 rtl/processing_core_ctrl.sv | 160 ++++++++++++++++
 tb/tb_processing_core_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/processing_core_ctrl.sv
// rtl/processing_core_ctrl.sv - per-channel ap_start/ap_ready/ap_done dispatch FSMs with hang timeout and sticky errors
module processing_core_ctrl #(
  parameter int N_CH    = 4,
  parameter int TIMEOUT = 1024,
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  input  logic [CH_W-1:0] cmd_ch,
  input  logic [1:0]      cmd_mode,
  output logic            cmd_ready,
  output logic [N_CH-1:0] ap_start,
  input  logic [N_CH-1:0] ap_ready,
  input  logic [N_CH-1:0] ap_done,
  output logic [N_CH-1:0] data_ready,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] timeout_err,
  output logic            bad_cmd,
  input  logic [N_CH:0]   err_clr
);

  // TIMEOUT >= 2, so the counter is always at least one bit wide
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ_EXEC = 3'd1,
    S_CUM_EXEC  = 3'd2,
    S_CUM_WAIT  = 3'd3,
    S_CUM_SEND  = 3'd4
  } state_e;

  state_e             state_q [N_CH];
  state_e             state_d [N_CH];
  logic [CNT_W-1:0]   cnt_q   [N_CH];
  logic [CNT_W-1:0]   cnt_d   [N_CH];
  // 1 = release on ap_done, 0 = release on ap_ready
  logic [N_CH-1:0]    mode_done_q, mode_done_d;
  logic [N_CH-1:0]    timeout_err_q, timeout_err_d;
  logic               bad_cmd_q, bad_cmd_d;

  logic [N_CH-1:0]    ch_hit;
  logic [N_CH-1:0]    idle_vec;
  logic               ch_valid;
  logic               accept;
  logic [N_CH-1:0]    to_set;
  logic               bad_set;

  // Channel decode and acceptance; out-of-range channels are always accepted so they can be flagged
  always_comb begin
    ch_hit   = '0;
    idle_vec = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_hit[i]   = (cmd_ch == CH_W'(i));
      idle_vec[i] = (state_q[i] == S_IDLE);
    end
    ch_valid  = |ch_hit;
    cmd_ready = !ch_valid || (|(ch_hit & idle_vec));
    accept    = cmd_valid && cmd_ready;
    bad_set   = accept && (!ch_valid || (cmd_mode == 2'b11));
  end

  // Per-channel next-state, counter and mode; an exit condition always beats the timeout
  always_comb begin
    to_set = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i]     = state_q[i];
      cnt_d[i]       = cnt_q[i];
      mode_done_d[i] = mode_done_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (accept && ch_hit[i] && (cmd_mode != 2'b11)) begin
            if (cmd_mode == 2'b00) begin
              state_d[i] = S_READ_EXEC;
            end else begin
              state_d[i]     = S_CUM_EXEC;
              cnt_d[i]       = '0;
              mode_done_d[i] = cmd_mode[1];
            end
          end
        end
        S_READ_EXEC, S_CUM_SEND: begin
          state_d[i] = S_IDLE;
        end
        S_CUM_EXEC: begin
          if (ap_ready[i]) begin
            if (!mode_done_q[i] || ap_done[i]) begin
              state_d[i] = S_CUM_SEND;
            end else begin
              state_d[i] = S_CUM_WAIT;
              cnt_d[i]   = '0;
            end
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = S_IDLE;
            to_set[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        S_CUM_WAIT: begin
          if (ap_done[i]) begin
            state_d[i] = S_CUM_SEND;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = S_IDLE;
            to_set[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = S_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags: a set in the same cycle as a clear wins
  always_comb begin
    timeout_err_d = (timeout_err_q & ~err_clr[N_CH-1:0]) | to_set;
    bad_cmd_d     = (bad_cmd_q & ~err_clr[N_CH]) | bad_set;
  end

  // State registers; async reset drops every channel back to IDLE at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      mode_done_q   <= '0;
      timeout_err_q <= '0;
      bad_cmd_q     <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      mode_done_q   <= mode_done_d;
      timeout_err_q <= timeout_err_d;
      bad_cmd_q     <= bad_cmd_d;
    end
  end

  // Moore output decode from registered state
  always_comb begin
    ap_start   = '0;
    data_ready = '0;
    busy       = '0;
    for (int i = 0; i < N_CH; i++) begin
      ap_start[i]   = (state_q[i] == S_CUM_EXEC);
      data_ready[i] = (state_q[i] == S_READ_EXEC) || (state_q[i] == S_CUM_SEND);
      busy[i]       = (state_q[i] != S_IDLE);
    end
    timeout_err = timeout_err_q;
    bad_cmd     = bad_cmd_q;
  end

endmodule

// File: tb/tb_processing_core_ctrl.sv
// tb/tb_processing_core_ctrl.sv - scoreboard bench for processing_core_ctrl
module tb_processing_core_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [2:0] cmd_ch;
  logic [1:0] cmd_mode;
  logic       cmd_ready;
  logic [3:0] ap_start, ap_ready, ap_done, data_ready, busy, timeout_err;
  logic       bad_cmd;
  logic [4:0] err_clr;

  processing_core_ctrl #(.N_CH(4), .TIMEOUT(8), .CH_W(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch), .cmd_mode(cmd_mode),
    .cmd_ready(cmd_ready), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .data_ready(data_ready), .busy(busy), .timeout_err(timeout_err), .bad_cmd(bad_cmd),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] dr;
    logic [3:0] to;
  } ev_t;

  ev_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;

  // expected output events, kept sorted by cycle and merged per cycle
  function automatic void expect_ev(input int c, input logic [3:0] dr, input logic [3:0] to);
    ev_t e;
    e.cyc = c; e.dr = dr; e.to = to;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc == c) begin
        sb[i].dr = sb[i].dr | dr;
        sb[i].to = sb[i].to | to;
        return;
      end
      if (sb[i].cyc > c) begin
        sb.insert(i, e);
        return;
      end
    end
    sb.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int ch, input int mode, output int t);
    cmd_valid = 1'b1;
    cmd_ch    = ch[2:0];
    cmd_mode  = mode[1:0];
    #1;
    chk("cmd_ready_issue", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    t = cyc;
  endtask

  // monitor: every data_ready pulse or timeout_err rise must match the scoreboard head
  logic [3:0] prev_to = '0;
  logic [3:0] ev_dr, ev_to;
  ev_t        head;
  always @(negedge clk) begin
    if (rst) begin
      prev_to = '0;
    end else begin
      ev_dr   = data_ready;
      ev_to   = timeout_err & ~prev_to;
      prev_to = timeout_err;
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        head = sb.pop_front();
        n_vec++; n_err++;
        $display("FAIL missed_event: got nothing expected dr=%b to=%b at cyc %0d", head.dr, head.to, head.cyc);
      end
      if (ev_dr != 4'b0 || ev_to != 4'b0) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: got dr=%b to=%b expected none (cyc %0d)", ev_dr, ev_to, cyc);
        end else begin
          head = sb.pop_front();
          if (head.cyc != cyc || head.dr != ev_dr || head.to != ev_to) begin
            n_err++;
            $display("FAIL event: got dr=%b to=%b at cyc %0d expected dr=%b to=%b at cyc %0d",
                     ev_dr, ev_to, cyc, head.dr, head.to, head.cyc);
          end
        end
      end
    end
  end

  int t, t0;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_mode = '0;
    ap_ready = '0; ap_done = '0; err_clr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_ap_start", 32'(ap_start), 32'h0);
    chk("rst_data_ready", 32'(data_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout_err", 32'(timeout_err), 32'h0);
    chk("rst_bad_cmd", 32'(bad_cmd), 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    tick();

    // READ on ch2: one-cycle data_ready/busy right after accept
    issue(2, 0, t);
    expect_ev(t, 4'b0100, 4'b0000);
    chk("read_busy", 32'(busy), 32'h4);
    chk("read_cmd_ready_busy", 32'(cmd_ready), 32'h0);
    tick();
    chk("read_busy_after", 32'(busy), 32'h0);
    chk("read_cmd_ready_after", 32'(cmd_ready), 32'h1);

    // CUM_RDY on ch0: ap_ready in 5th ap_start cycle, ap_done held high and ignored
    ap_done[0] = 1'b1;
    issue(0, 1, t);
    expect_ev(t + 5, 4'b0001, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      chk("rdy_ap_start", 32'(ap_start[0]), 32'h1);
      ap_ready[0] = (k == 4);
      tick();
    end
    ap_ready[0] = 1'b0;
    chk("rdy_ap_start_low", 32'(ap_start[0]), 32'h0);
    tick();
    ap_done[0] = 1'b0;

    // CUM_DONE on ch1: ap_ready at k=2, ap_done at k=9
    issue(1, 2, t);
    expect_ev(t + 10, 4'b0010, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      chk("done_ap_start", 32'(ap_start[1]), 32'((k <= 2) ? 1 : 0));
      ap_ready[1] = (k == 2);
      ap_done[1]  = (k == 9);
      tick();
    end
    ap_ready[1] = 1'b0; ap_done[1] = 1'b0;
    tick();

    // CUM_DONE on ch1 with ap_ready and ap_done together
    issue(1, 2, t);
    expect_ev(t + 3, 4'b0010, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      ap_ready[1] = (k == 2);
      ap_done[1]  = (k == 2);
      tick();
    end
    ap_ready[1] = 1'b0; ap_done[1] = 1'b0;
    tick();

    // exit on the last counter value beats the timeout (ch2, CUM_RDY)
    issue(2, 1, t);
    expect_ev(t + 8, 4'b0100, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      ap_ready[2] = (k == 7);
      tick();
    end
    ap_ready[2] = 1'b0;
    tick();

    // timeout in CUM_WAIT on ch3
    issue(3, 2, t);
    expect_ev(t + 10, 4'b0000, 4'b1000);
    for (int k = 0; k < 10; k++) begin
      chk("to_busy", 32'(busy[3]), 32'h1);
      if (k == 9) chk("to_err_early", 32'(timeout_err[3]), 32'h0);
      ap_ready[3] = (k == 1);
      tick();
    end
    ap_ready[3] = 1'b0;
    chk("to_busy_after", 32'(busy[3]), 32'h0);
    chk("to_err_set", 32'(timeout_err[3]), 32'h1);
    err_clr[3] = 1'b1;
    tick();
    err_clr[3] = 1'b0;
    chk("to_err_clr", 32'(timeout_err[3]), 32'h0);

    // timeout in CUM_EXEC coinciding with err_clr: set wins
    issue(3, 1, t);
    expect_ev(t + 8, 4'b0000, 4'b1000);
    for (int k = 0; k < 8; k++) begin
      err_clr[3] = (k == 7);
      tick();
    end
    err_clr[3] = 1'b0;
    chk("to_set_wins", 32'(timeout_err[3]), 32'h1);

    // a flagged channel still accepts commands
    issue(3, 0, t);
    expect_ev(t, 4'b1000, 4'b0000);
    tick();
    err_clr[3] = 1'b1;
    tick();
    err_clr[3] = 1'b0;
    chk("to_err_clr2", 32'(timeout_err[3]), 32'h0);

    // concurrent channels and stall on busy ch0
    cmd_valid = 1'b1; cmd_ch = 3'd0; cmd_mode = 2'b01;
    #1;
    chk("conc_rdy0", 32'(cmd_ready), 32'h1);
    tick();
    t0 = cyc;
    expect_ev(t0 + 3, 4'b0001, 4'b0000);
    expect_ev(t0 + 5, 4'b0001, 4'b0000);
    expect_ev(t0 + 6, 4'b0010, 4'b0000);
    cmd_ch = 3'd1; cmd_mode = 2'b10;
    #1;
    chk("conc_rdy1", 32'(cmd_ready), 32'h1);
    tick();
    cmd_ch = 3'd0; cmd_mode = 2'b00;
    #1;
    chk("conc_stall_a", 32'(cmd_ready), 32'h0);
    tick();
    chk("conc_stall_b", 32'(cmd_ready), 32'h0);
    ap_ready[0] = 1'b1;
    tick();
    ap_ready[0] = 1'b0;
    ap_ready[1] = 1'b1;
    chk("conc_stall_c", 32'(cmd_ready), 32'h0);
    tick();
    ap_ready[1] = 1'b0;
    chk("conc_release", 32'(cmd_ready), 32'h1);
    chk("conc_ap_start1", 32'(ap_start[1]), 32'h0);
    tick();
    cmd_valid = 1'b0;
    ap_done[1] = 1'b1;
    tick();
    ap_done[1] = 1'b0;
    tick();

    // reserved mode and out-of-range channel
    issue(0, 3, t);
    chk("bad_mode_busy", 32'(busy), 32'h0);
    chk("bad_mode_flag", 32'(bad_cmd), 32'h1);
    err_clr[4] = 1'b1;
    tick();
    err_clr[4] = 1'b0;
    chk("bad_clr", 32'(bad_cmd), 32'h0);
    issue(4, 0, t);
    chk("bad_ch_busy", 32'(busy), 32'h0);
    chk("bad_ch_flag", 32'(bad_cmd), 32'h1);
    err_clr[4] = 1'b1;
    tick();
    chk("bad_clr2", 32'(bad_cmd), 32'h0);
    issue(0, 3, t);
    err_clr[4] = 1'b0;
    chk("bad_set_wins", 32'(bad_cmd), 32'h1);
    tick();

    // async reset mid CUM_EXEC
    issue(2, 1, t);
    tick();
    chk("pre_rst_ap_start", 32'(ap_start), 32'h4);
    rst = 1'b1;
    #1;
    chk("arst_ap_start", 32'(ap_start), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_data_ready", 32'(data_ready), 32'h0);
    chk("arst_timeout_err", 32'(timeout_err), 32'h0);
    chk("arst_bad_cmd", 32'(bad_cmd), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
